s_seq_packer: RTL and testbench

- Upstream feeder for the alignment top level. Accepts the query sequence S one 2-bit base per cycle from the host stream.
- Packs bases into PE-array-wide words, buffers the words in a small FIFO, and answers the core's S-request pulse with one word plus a valid-base count.
- Drives the core's S-data and S-valid-count inputs directly, so the core never stalls on host byte-level timing.

---
 rtl/s_seq_packer_if.sv | 39 +++
 rtl/s_seq_packer.sv | 128 ++++++++++++
 tb/tb_s_seq_packer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/s_seq_packer_if.sv
// Host-stream and core-facing signals of the S-sequence packer.
// The stats ports exist only when S_SEQ_PACKER_STATS_EN is defined.
interface s_seq_packer_if #(
   parameter int PE_SIZE     = 64,
   parameter int PE_SIZE_LOG = 6
);
   logic [1:0]             i_base;
   logic                   i_base_valid;
   logic                   i_base_last;
   logic                   o_base_ready;
   logic                   i_flush;
   logic                   i_request_s;
   logic [2*PE_SIZE-1:0]   o_s;
   logic [PE_SIZE_LOG:0]   o_s_valid;
   logic                   o_s_last;
   logic                   o_empty;
`ifdef S_SEQ_PACKER_STATS_EN
   logic [15:0]            o_base_cnt;
   logic [15:0]            o_word_cnt;

   modport master (
      output i_base, i_base_valid, i_base_last, i_flush, i_request_s,
      input  o_base_ready, o_s, o_s_valid, o_s_last, o_empty, o_base_cnt, o_word_cnt
   );
   modport slave (
      input  i_base, i_base_valid, i_base_last, i_flush, i_request_s,
      output o_base_ready, o_s, o_s_valid, o_s_last, o_empty, o_base_cnt, o_word_cnt
   );
`else
   modport master (
      output i_base, i_base_valid, i_base_last, i_flush, i_request_s,
      input  o_base_ready, o_s, o_s_valid, o_s_last, o_empty
   );
   modport slave (
      input  i_base, i_base_valid, i_base_last, i_flush, i_request_s,
      output o_base_ready, o_s, o_s_valid, o_s_last, o_empty
   );
`endif
endinterface

// File: rtl/s_seq_packer.sv
// Packs 2-bit bases into PE_SIZE-wide words, buffers them and serves core requests.
// Optional base/word counters are enabled with S_SEQ_PACKER_STATS_EN.
module s_seq_packer #(
   parameter int PE_SIZE     = 64,
   parameter int PE_SIZE_LOG = 6,
   parameter int FIFO_DEPTH  = 4
)(
   input  logic            clk,
   input  logic            rst_n,
   s_seq_packer_if.slave   bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [PE_SIZE_LOG:0] LAST_POS = (PE_SIZE_LOG+1)'(PE_SIZE-1);
   localparam logic [PE_SIZE_LOG:0] CNT_ONE  = (PE_SIZE_LOG+1)'(1);
   localparam logic [AW:0]          PTR_ONE  = (AW+1)'(1);

   typedef enum logic {FILL, PUSH} state_t;
   state_t state_q, state_d;

   logic [PE_SIZE-1:0][1:0]                 asm_word;
   logic [PE_SIZE_LOG:0]                    asm_cnt;
   logic                                    asm_last;
   logic [FIFO_DEPTH-1:0][2*PE_SIZE-1:0]    mem_w;
   logic [FIFO_DEPTH-1:0][PE_SIZE_LOG:0]    mem_c;
   logic [FIFO_DEPTH-1:0]                   mem_l;
   logic [AW:0]                             wr_ptr, rd_ptr;
   logic fifo_empty, fifo_full, accept, enq, pop, pend;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign accept     = (state_q == FILL) & bus.i_base_valid & ~bus.i_flush;
   assign enq        = (state_q == PUSH) & ~fifo_full & ~bus.i_flush;
   // A pending request is served as soon as a word is at the head.
   assign pop        = ~fifo_empty & (bus.i_request_s | pend) & ~bus.i_flush;

   assign bus.o_base_ready = (state_q == FILL);
   assign bus.o_empty      = fifo_empty & (asm_cnt == '0) & (state_q == FILL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FILL;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.i_flush) state_d = FILL;
      else begin
         case (state_q)
            FILL:    if (accept && (asm_cnt == LAST_POS || bus.i_base_last)) state_d = PUSH;
            PUSH:    if (!fifo_full) state_d = FILL;
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_word <= '0;
         asm_cnt  <= '0;
         asm_last <= 1'b0;
      end else if (bus.i_flush || enq) begin
         asm_word <= '0;
         asm_cnt  <= '0;
         asm_last <= 1'b0;
      end else if (accept) begin
         asm_word[asm_cnt[PE_SIZE_LOG-1:0]] <= bus.i_base;
         asm_cnt  <= asm_cnt + CNT_ONE;
         asm_last <= bus.i_base_last;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         mem_w[wr_ptr[AW-1:0]] <= asm_word;
         mem_c[wr_ptr[AW-1:0]] <= asm_cnt;
         mem_l[wr_ptr[AW-1:0]] <= asm_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         pend   <= 1'b0;
      end else if (bus.i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         pend   <= 1'b0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         // A request arriving alongside a pending-driven pop stays queued.
         if (pop) pend <= pend & bus.i_request_s;
         else     pend <= pend | bus.i_request_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.o_s       <= '0;
         bus.o_s_valid <= '0;
         bus.o_s_last  <= 1'b0;
      end else if (pop) begin
         bus.o_s       <= mem_w[rd_ptr[AW-1:0]];
         bus.o_s_valid <= mem_c[rd_ptr[AW-1:0]];
         bus.o_s_last  <= mem_l[rd_ptr[AW-1:0]];
      end else begin
         bus.o_s       <= '0;
         bus.o_s_valid <= '0;
         bus.o_s_last  <= 1'b0;
      end
   end

`ifdef S_SEQ_PACKER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.o_base_cnt <= '0;
         bus.o_word_cnt <= '0;
      end else if (bus.i_flush) begin
         bus.o_base_cnt <= '0;
         bus.o_word_cnt <= '0;
      end else begin
         if (accept && !(&bus.o_base_cnt)) bus.o_base_cnt <= bus.o_base_cnt + 16'd1;
         if (pop && !(&bus.o_word_cnt))    bus.o_word_cnt <= bus.o_word_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_s_seq_packer.sv
// Randomized + directed bench for s_seq_packer against a queue-based reference model.
module tb_s_seq_packer;
   localparam int PE    = 4;
   localparam int PL    = 2;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [2*PE-1:0] w;
      logic [PL:0]     c;
      logic            l;
   } wrd_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   s_seq_packer_if #(.PE_SIZE(PE), .PE_SIZE_LOG(PL)) bus ();
   s_seq_packer #(.PE_SIZE(PE), .PE_SIZE_LOG(PL), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: words as a queue, partial word as a list of bases.
   wrd_t mq[$];
   int   part[$];
   bit   m_push, m_plast, m_pend;
   wrd_t m_out;
   int   m_bcnt, m_wcnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete(); part.delete();
      m_push = 0; m_plast = 0; m_pend = 0; m_out = '0; m_bcnt = 0; m_wcnt = 0;
   endtask

   task automatic model_step(input bit v, input logic [1:0] b, input bit l, input bit r, input bit f);
      wrd_t nxt, nw;
      bit   pop, rdy, was_full;
      nxt = '0;
      if (f) begin
         model_reset();
         return;
      end
      rdy      = !m_push;
      was_full = (mq.size() == DEPTH);
      pop      = (mq.size() != 0) && (r || m_pend);
      if (pop) begin
         nxt = mq.pop_front();
         if (m_wcnt < 65535) m_wcnt++;
         m_pend = m_pend && r;
      end else m_pend = m_pend || r;
      if (m_push && !was_full) begin
         nw = '0;
         for (int k = 0; k < part.size(); k++) nw.w = nw.w | ((2*PE)'(part[k]) << (2*k));
         nw.c = (PL+1)'(part.size());
         nw.l = m_plast;
         mq.push_back(nw);
         part.delete();
         m_push = 0;
      end else if (rdy && v) begin
         part.push_back(int'(b));
         if (m_bcnt < 65535) m_bcnt++;
         if (part.size() == PE || l) begin
            m_push = 1; m_plast = l;
         end
      end
      m_out = nxt;
   endtask

   task automatic check_outputs();
      chk("s",       64'(bus.o_s),          64'(m_out.w));
      chk("s_valid", 64'(bus.o_s_valid),    64'(m_out.c));
      chk("s_last",  64'(bus.o_s_last),     64'(m_out.l));
      chk("ready",   64'(bus.o_base_ready), 64'(!m_push));
      chk("empty",   64'(bus.o_empty),      64'(mq.size() == 0 && part.size() == 0 && !m_push));
`ifdef S_SEQ_PACKER_STATS_EN
      chk("base_cnt", 64'(bus.o_base_cnt), 64'(m_bcnt));
      chk("word_cnt", 64'(bus.o_word_cnt), 64'(m_wcnt));
`endif
   endtask

   // One clock: drive at negedge, step model, check after the edge.
   task automatic cyc(input bit v, input logic [1:0] b, input bit l, input bit r, input bit f);
      bus.i_base = b; bus.i_base_valid = v; bus.i_base_last = l;
      bus.i_request_s = r; bus.i_flush = f;
      model_step(v, b, l, r, f);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 2'd0, 0, 0, 0);
   endtask

   task automatic send(input logic [1:0] b, input bit l);
      bit acc;
      for (int k = 0; k < 20; k++) begin
         acc = !m_push;
         cyc(1, b, l, 0, 0);
         if (acc) return;
      end
      chk("send_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      bus.i_base = '0; bus.i_base_valid = 0; bus.i_base_last = 0;
      bus.i_request_s = 0; bus.i_flush = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_s",       64'(bus.o_s), 64'd0);
      chk("rst_s_valid", 64'(bus.o_s_valid), 64'd0);
      chk("rst_s_last",  64'(bus.o_s_last), 64'd0);
      chk("rst_empty",   64'(bus.o_empty), 64'd1);
      rst_n = 1'b1;

      // Single word with last, then request.
      send(2'd0, 0); send(2'd1, 0); send(2'd2, 0); send(2'd3, 1);
      idle(1);
      cyc(0, 2'd0, 0, 1, 0);
      chk("t1_s", 64'(bus.o_s), 64'hE4);
      chk("t1_cnt", 64'(bus.o_s_valid), 64'd4);
      chk("t1_last", 64'(bus.o_s_last), 64'd1);
      idle(1);
      chk("t1_one_cycle", 64'(bus.o_s_valid), 64'd0);

      // Two words: full word then 2-base tail.
      send(2'd3, 0); send(2'd3, 0); send(2'd3, 0); send(2'd3, 0);
      send(2'd1, 0); send(2'd2, 1);
      idle(2);
      cyc(0, 2'd0, 0, 1, 0);
      chk("t2a_s", 64'(bus.o_s), 64'hFF);
      chk("t2a_cnt", 64'(bus.o_s_valid), 64'd4);
      chk("t2a_last", 64'(bus.o_s_last), 64'd0);
      cyc(0, 2'd0, 0, 1, 0);
      chk("t2b_s", 64'(bus.o_s), 64'h09);
      chk("t2b_cnt", 64'(bus.o_s_valid), 64'd2);
      chk("t2b_last", 64'(bus.o_s_last), 64'd1);
      idle(1);

      // Pending request, data arrives later.
      cyc(0, 2'd0, 0, 1, 0);
      idle(3);
      chk("t3_nodata", 64'(bus.o_s_valid), 64'd0);
      send(2'd2, 0); send(2'd0, 0); send(2'd1, 0); send(2'd3, 0);
      idle(1);
      idle(1);
      chk("t3_s", 64'(bus.o_s), 64'hD2);
      chk("t3_cnt", 64'(bus.o_s_valid), 64'd4);
      idle(1);
      chk("t3_cleared", 64'(bus.o_s_valid), 64'd0);

      // FIFO full back-pressure.
      for (int i = 0; i < 12; i++) send(2'(i), 0);
      idle(2);
      chk("t4_stall", 64'(bus.o_base_ready), 64'd0);
      cyc(0, 2'd0, 0, 1, 0);
      idle(1);
      chk("t4_resume", 64'(bus.o_base_ready), 64'd1);
      for (int i = 0; i < 4; i++) cyc(0, 2'd0, 0, 1, 0);

      // Flush with two words queued and a partial word; base and request in the flush cycle dropped.
      for (int i = 0; i < 10; i++) send(2'(3 - (i % 4)), 0);
      cyc(1, 2'd1, 0, 1, 1);
      chk("t5_empty", 64'(bus.o_empty), 64'd1);
      cyc(0, 2'd0, 0, 1, 0);
      idle(3);
      chk("t5_nothing", 64'(bus.o_s_valid), 64'd0);
      send(2'd1, 0); send(2'd1, 1);
      idle(2);
      chk("t5_newdata", 64'(bus.o_s_valid), 64'd2);

      // Reset mid-delivery.
      send(2'd3, 0); send(2'd2, 1);
      idle(1);
      cyc(0, 2'd0, 0, 1, 0);
      #1 rst_n = 1'b0;
      #1 chk("t6_rst_valid", 64'(bus.o_s_valid), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      send(2'd0, 0); send(2'd1, 0); send(2'd2, 0); send(2'd3, 1);
      idle(1);
      cyc(0, 2'd0, 0, 1, 0);
      chk("t6_s", 64'(bus.o_s), 64'hE4);
      idle(1);
`ifdef S_SEQ_PACKER_STATS_EN
      chk("t6_bcnt", 64'(bus.o_base_cnt), 64'd4);
      chk("t6_wcnt", 64'(bus.o_word_cnt), 64'd1);
`endif

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         cyc($urandom_range(0, 9) < 6, 2'($urandom), $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
